route_sched: RTL and testbench
==============================

// Module: route_sched
// PURPOSE
//  Sequences the 36-bit route ctrl word of the data-route crossbar through a programmed list of route entries.
//  Each entry holds a ctrl word, a beat count and a watched output port (a..h).
//  The block holds the route until that many beats have handshaked on the watched output.
//  It then gates all switch tvalid enables for a guard gap before loading the next entry, so ctrl never changes mid-transfer.
// PARAMETERS
//  DEPTH    16  route table entries
//  IDX_W    4   log2(DEPTH)
//  BEAT_W   20  beat-count width per entry
//  GAP_CYC  4   guard cycles with tvalid enables gated between entries (>=1)
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active-high
//  tbl_wr_en     in   1       table write strobe (honoured only when busy=0)
//  tbl_wr_addr   in   IDX_W   table write address
//  tbl_wr_ctrl   in   36      entry route ctrl word
//  tbl_wr_beats  in   BEAT_W  entry beat count; 0 = skip entry
//  tbl_wr_sel    in   3       watched output: 0=a,1=b,..,7=h
//  start         in   1       pulse: run entries 0..num_entries-1
//  num_entries   in   IDX_W+1 entries to run (0..DEPTH)
//  stop          in   1       abort the sequence
//  out_fire      in   8       per-output valid&ready, bit0=a..bit7=h
//  route_ctrl    out  36      registered ctrl word to the crossbar
//  busy          out  1       sequence in progress
//  done          out  1       1-cycle pulse on normal completion
//  aborted       out  1       1-cycle pulse on stop
//  cur_idx       out  IDX_W   entry being executed
// BEHAVIOUR
//  Reset: route_ctrl=0, busy=0, done=0, aborted=0, cur_idx=0, state IDLE, counters 0. Table RAM not reset (contents preserved across rst).
//  GATE_MASK=36'hFFF03FFC0: clears switch_tvalid_in/out fields [5:0],[23:18]; keeps flex-shift fields.
//  IDLE:
//   - start && num_entries>0: cur_idx<=0, ->LOAD.
//   - start && num_entries==0: done=1 next cycle, stay IDLE.
//  LOAD (1 cycle, sync table read):
//   - beats==0: ->GAP, route_ctrl unchanged.
//   - else: route_ctrl<=entry.ctrl, beat_cnt<=0, ->RUN.
//   - start at cycle t: route_ctrl valid at t+2.
//  RUN:
//   - beat_cnt increments on out_fire[entry.sel].
//   - fire with beat_cnt==beats-1: route_ctrl<=route_ctrl&GATE_MASK, gap_cnt<=0, ->GAP.
//   - out_fire bits other than sel are ignored.
//  GAP: holds GAP_CYC cycles. Then:
//   - cur_idx==num_entries-1: ->FIN.
//   - else: cur_idx++, ->LOAD.
//  FIN: route_ctrl<=0, done=1 for one cycle, ->IDLE.
//  busy=1 in every state except IDLE.
//  num_entries is sampled at start; later changes are ignored.
//  start while busy: ignored.
//  tbl_wr_en while busy: ignored, table unchanged.
//  stop (any non-IDLE state, priority over all transitions): next cycle route_ctrl=0, aborted=1 for one cycle, ->IDLE; done not asserted.
//  stop in IDLE: no effect.
//  beat_cnt saturates at 2^BEAT_W-1; no wrap.
//  rst mid-sequence: immediate return to reset values, no done/aborted pulse.
// CONFIGURATION
//  ROUTE_SCHED_LOOP_EN defined:
//   - extra input port loop_en (1 bit).
//   - FIN with loop_en=1: cur_idx<=0, ->LOAD, no done pulse, route_ctrl stays gated until LOAD.
//   - only stop or rst ends a looping sequence.
//  Undefined: port absent; FIN always completes.
// STRUCTURE
//  Package route_sched_pkg: state enum (IDLE,LOAD,RUN,GAP,FIN), GATE_MASK, CTRL_W=36, entry struct {ctrl,beats,sel}.
//  Sub-module route_sched_tbl: DEPTH x (36+BEAT_W+3) RAM, 1 write port, 1-cycle sync read port.
// TESTING
//  - 2 entries {ctrl=36'h0_0000_0009, beats=3, sel=0}, {ctrl=36'h0_0024_0000, beats=2, sel=5}, num=2, start:
//    route_ctrl=0x9 from t+2; 3 fires on bit0 -> 0x0 for 4 cycles; then 0x240000; 2 fires on bit5 -> done, route_ctrl=0.
//  - Entry 0 beats=0, entry 1 beats=1, num=2: entry 0 skipped; route_ctrl never takes entry-0 ctrl; done after 1 fire.
//  - Entry sel=2, fires on bits 0,1,3 only: route_ctrl holds, no advance; one fire on bit2 (beats=1) -> GAP.
//  - stop mid-RUN: next cycle route_ctrl=0, aborted=1, busy=0, no done; a following start re-runs from entry 0.
//  - tbl_wr_en and start while busy: table unchanged on readback run, sequence unaffected; start with num=0 -> done pulse, busy never 1.
//  - ROUTE_SCHED_LOOP_EN, loop_en=1, num=1, beats=1: entry reloads after each GAP, no done; stop -> aborted.

Source files
------------

// File: rtl/route_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : route_sched_pkg
// Purpose  : Shared sizes, FSM states, gate mask and route-entry layout for
//            the crossbar route scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package route_sched_pkg;

    localparam int DEPTH   = 16;
    localparam int IDX_W   = 4;
    localparam int BEAT_W  = 20;
    localparam int GAP_CYC = 4;
    localparam int CTRL_W  = 36;
    localparam int SEL_W   = 3;

    // Clears the switch tvalid enable fields [5:0] and [23:18] only
    localparam logic [CTRL_W-1:0] GATE_MASK = 36'hFFF03FFC0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [BEAT_W-1:0] beats;
        logic [SEL_W-1:0]  sel;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage
`default_nettype wire

// File: rtl/route_sched_tbl.sv
`default_nettype none
// ============================================================================
// Module   : route_sched_tbl
// Purpose  : Route entry table, one write port and one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module route_sched_tbl
    import route_sched_pkg::*;
(
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_addr,
    input  logic [ENTRY_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]   i_rd_addr,
    output logic [ENTRY_W-1:0] o_rd_data
);

    // Contents deliberately survive reset so a table can be reused after rst
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_rd_data_q;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data_q <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data_q;

endmodule
`default_nettype wire

// File: rtl/route_sched.sv
`default_nettype none
// ============================================================================
// Module   : route_sched
// Purpose  : Steps the crossbar route ctrl word through a programmed entry
//            list, holding each route for a beat count and gating tvalid
//            enables for a guard gap between entries.
// Config   : ROUTE_SCHED_LOOP_EN adds input loop_en to repeat the list.
// Revision : 1.0 - initial release
// ============================================================================
module route_sched
    import route_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_wr_en,
    input  logic [IDX_W-1:0]  tbl_wr_addr,
    input  logic [CTRL_W-1:0] tbl_wr_ctrl,
    input  logic [BEAT_W-1:0] tbl_wr_beats,
    input  logic [SEL_W-1:0]  tbl_wr_sel,
    input  logic              start,
    input  logic [IDX_W:0]    num_entries,
    input  logic              stop,
    input  logic [7:0]        out_fire,
`ifdef ROUTE_SCHED_LOOP_EN
    input  logic              loop_en,
`endif
    output logic [CTRL_W-1:0] route_ctrl,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [IDX_W-1:0]  cur_idx
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t             r_state_q,      w_state_d;
    logic [IDX_W-1:0]   r_cur_idx_q,    w_cur_idx_d;
    logic [IDX_W:0]     r_num_q,        w_num_d;
    logic [CTRL_W-1:0]  r_route_ctrl_q, w_route_ctrl_d;
    logic [BEAT_W-1:0]  r_beat_cnt_q,   w_beat_cnt_d;
    logic [GAP_W-1:0]   r_gap_cnt_q,    w_gap_cnt_d;
    logic               r_done_q,       w_done_d;
    logic               r_aborted_q,    w_aborted_d;

    logic [ENTRY_W-1:0] w_rd_raw;
    entry_t             w_entry;
    logic               w_busy;
    logic               w_fire;
    logic               w_last;
    logic               w_loop;

`ifdef ROUTE_SCHED_LOOP_EN
    assign w_loop = loop_en;
`else
    assign w_loop = 1'b0;
`endif

    assign w_busy  = (r_state_q != IDLE);
    assign w_entry = entry_t'(w_rd_raw);
    assign w_fire  = out_fire[w_entry.sel];
    assign w_last  = ({1'b0, r_cur_idx_q} == (r_num_q - (IDX_W+1)'(1)));

    // Reading at the next index means the entry is already registered in LOAD
    route_sched_tbl u_tbl (
        .clk       (clk),
        .i_wr_en   (tbl_wr_en & ~w_busy),
        .i_wr_addr (tbl_wr_addr),
        .i_wr_data ({tbl_wr_ctrl, tbl_wr_beats, tbl_wr_sel}),
        .i_rd_addr (w_cur_idx_d),
        .o_rd_data (w_rd_raw)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_cur_idx_d    = r_cur_idx_q;
        w_num_d        = r_num_q;
        w_route_ctrl_d = r_route_ctrl_q;
        w_beat_cnt_d   = r_beat_cnt_q;
        w_gap_cnt_d    = '0;
        w_done_d       = 1'b0;
        w_aborted_d    = 1'b0;

        if (w_busy && stop) begin
            w_route_ctrl_d = '0;
            w_aborted_d    = 1'b1;
            w_state_d      = IDLE;
        end else begin
            case (r_state_q)
                IDLE: begin
                    if (start) begin
                        if (num_entries != '0) begin
                            w_num_d     = num_entries;
                            w_cur_idx_d = '0;
                            w_state_d   = LOAD;
                        end else begin
                            w_done_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_entry.beats == '0) begin
                        w_state_d = GAP;
                    end else begin
                        w_route_ctrl_d = w_entry.ctrl;
                        w_beat_cnt_d   = '0;
                        w_state_d      = RUN;
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        if (!(&r_beat_cnt_q)) begin
                            w_beat_cnt_d = r_beat_cnt_q + BEAT_W'(1);
                        end
                        if (r_beat_cnt_q == (w_entry.beats - BEAT_W'(1))) begin
                            w_route_ctrl_d = r_route_ctrl_q & GATE_MASK;
                            w_state_d      = GAP;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                        if (w_last) begin
                            w_state_d = FIN;
                        end else begin
                            w_cur_idx_d = r_cur_idx_q + IDX_W'(1);
                            w_state_d   = LOAD;
                        end
                    end else begin
                        w_gap_cnt_d = r_gap_cnt_q + GAP_W'(1);
                    end
                end
                FIN: begin
                    if (w_loop) begin
                        // Route stays gated until entry 0 is reloaded
                        w_cur_idx_d = '0;
                        w_state_d   = LOAD;
                    end else begin
                        w_route_ctrl_d = '0;
                        w_done_d       = 1'b1;
                        w_state_d      = IDLE;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_cur_idx_q    <= '0;
            r_num_q        <= '0;
            r_route_ctrl_q <= '0;
            r_beat_cnt_q   <= '0;
            r_gap_cnt_q    <= '0;
            r_done_q       <= 1'b0;
            r_aborted_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cur_idx_q    <= w_cur_idx_d;
            r_num_q        <= w_num_d;
            r_route_ctrl_q <= w_route_ctrl_d;
            r_beat_cnt_q   <= w_beat_cnt_d;
            r_gap_cnt_q    <= w_gap_cnt_d;
            r_done_q       <= w_done_d;
            r_aborted_q    <= w_aborted_d;
        end
    end

    assign route_ctrl = r_route_ctrl_q;
    assign busy       = w_busy;
    assign done       = r_done_q;
    assign aborted    = r_aborted_q;
    assign cur_idx    = r_cur_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_route_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_route_sched
// Purpose  : Self-checking bench for route_sched against an entry-level model
//            of route timing (load, hold for N beats, guard gap, finish).
// Revision : 1.0 - initial release
// ============================================================================
module tb_route_sched;

    localparam logic [35:0] C_GATE = 36'hFFF03FFC0;
    localparam int          C_GAPC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tbl_wr_en;
    logic [3:0]  tbl_wr_addr;
    logic [35:0] tbl_wr_ctrl;
    logic [19:0] tbl_wr_beats;
    logic [2:0]  tbl_wr_sel;
    logic        start;
    logic [4:0]  num_entries;
    logic        stop;
    logic [7:0]  out_fire;
`ifdef ROUTE_SCHED_LOOP_EN
    logic        loop_en;
`endif
    logic [35:0] route_ctrl;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [3:0]  cur_idx;

    logic [35:0] m_ctrl  [16];
    logic [19:0] m_beats [16];
    logic [2:0]  m_sel   [16];
    logic [35:0] m_route;
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          busy_noise = 1'b0;

    always #5 clk = ~clk;

    route_sched dut (
        .clk          (clk),
        .rst          (rst),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_addr  (tbl_wr_addr),
        .tbl_wr_ctrl  (tbl_wr_ctrl),
        .tbl_wr_beats (tbl_wr_beats),
        .tbl_wr_sel   (tbl_wr_sel),
        .start        (start),
        .num_entries  (num_entries),
        .stop         (stop),
        .out_fire     (out_fire),
`ifdef ROUTE_SCHED_LOOP_EN
        .loop_en      (loop_en),
`endif
        .route_ctrl   (route_ctrl),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .cur_idx      (cur_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic quiet();
        busy_noise  = 1'b0;
        tbl_wr_en   = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        out_fire    = 8'h00;
    endtask

    // Advance one cycle; while busy, optionally spray writes/starts that must be ignored
    task automatic tick();
        if (busy_noise) begin
            tbl_wr_en    = 1'($urandom);
            tbl_wr_addr  = 4'($urandom);
            tbl_wr_ctrl  = {4'($urandom), 32'($urandom)};
            tbl_wr_beats = 20'($urandom);
            tbl_wr_sel   = 3'($urandom);
            start        = 1'($urandom);
            num_entries  = 5'($urandom_range(0, 16));
        end
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [35:0] c, input int b, input int s);
        tbl_wr_en    = 1'b1;
        tbl_wr_addr  = 4'(a);
        tbl_wr_ctrl  = c;
        tbl_wr_beats = 20'(b);
        tbl_wr_sel   = 3'(s);
        @(negedge clk);
        tbl_wr_en    = 1'b0;
        m_ctrl[a]    = c;
        m_beats[a]   = 20'(b);
        m_sel[a]     = 3'(s);
    endtask

    function automatic logic [35:0] rnd_ctrl();
        return {4'($urandom), 32'($urandom)};
    endfunction

    // One start pulse, then the expected route timeline entry by entry
    task automatic run_seq(input int num, input int iters, input bit noisy,
                           input int stop_it, input int stop_ent);
        int cnt;
        int k;
        logic [7:0] f;
        start       = 1'b1;
        num_entries = 5'(num);
        out_fire    = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        if (num == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            @(negedge clk);
            chk("zero_done_end", done, 0);
            chk("zero_busy_end", busy, 0);
            return;
        end
        busy_noise = noisy;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < num; i++) begin
                chk("load_route", route_ctrl, m_route);
                chk("load_busy", busy, 1);
                chk("load_idx", cur_idx, i);
                out_fire = 8'($urandom);
                tick();
                if (m_beats[i] != 0) begin
                    cnt = 0;
                    k   = 0;
                    while (cnt < int'(m_beats[i])) begin
                        chk("run_route", route_ctrl, m_ctrl[i]);
                        chk("run_idx", cur_idx, i);
                        chk("run_flags", {busy, done, aborted}, 3'b100);
                        if (it == stop_it && i == stop_ent) begin
                            out_fire = 8'h00;
                            stop     = 1'b1;
                            tick();
                            quiet();
                            chk("stop_route", route_ctrl, 0);
                            chk("stop_flags", {busy, done, aborted}, 3'b001);
                            @(negedge clk);
                            chk("stop_pulse_end", {busy, done, aborted}, 3'b000);
                            m_route = '0;
                            return;
                        end
                        f = 8'($urandom);
                        f[m_sel[i]] = (k >= 3) && (($urandom_range(0, 2) == 0) || (k >= 40));
                        if (f[m_sel[i]]) cnt++;
                        k++;
                        out_fire = f;
                        tick();
                    end
                    m_route = m_ctrl[i] & C_GATE;
                end
                for (int g = 0; g < C_GAPC; g++) begin
                    chk("gap_route", route_ctrl, m_route);
                    chk("gap_flags", {busy, done, aborted}, 3'b100);
                    out_fire = 8'($urandom);
                    tick();
                end
            end
            chk("fin_route", route_ctrl, m_route);
            chk("fin_flags", {busy, done, aborted}, 3'b100);
            out_fire = 8'($urandom);
            tick();
        end
        quiet();
        chk("done_route", route_ctrl, 0);
        chk("done_flags", {busy, done, aborted}, 3'b010);
        @(negedge clk);
        chk("done_pulse_end", {busy, done, aborted}, 3'b000);
        m_route = '0;
    endtask

    initial begin
        rst          = 1'b1;
        tbl_wr_addr  = '0;
        tbl_wr_ctrl  = '0;
        tbl_wr_beats = '0;
        tbl_wr_sel   = '0;
        num_entries  = '0;
`ifdef ROUTE_SCHED_LOOP_EN
        loop_en      = 1'b0;
`endif
        quiet();
        m_route = '0;
        repeat (3) @(negedge clk);
        chk("rst_route", route_ctrl, 0);
        chk("rst_flags", {busy, done, aborted}, 3'b000);
        chk("rst_idx", cur_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_flags", {busy, done, aborted}, 3'b000);

        // Two-entry reference sequence
        wr(0, 36'h0_0000_0009, 3, 0);
        wr(1, 36'h0_0024_0000, 2, 5);
        run_seq(2, 1, 1'b0, -1, -1);

        // Zero-beat entry is skipped without touching route_ctrl
        wr(0, rnd_ctrl(), 0, 3'($urandom));
        wr(1, rnd_ctrl(), 1, 2);
        run_seq(2, 1, 1'b0, -1, -1);

        // Only the watched output advances the count
        wr(0, rnd_ctrl(), 1, 2);
        run_seq(1, 1, 1'b0, -1, -1);

        // Random tables and lengths
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 16; a++) begin
                wr(a, rnd_ctrl(), $urandom_range(0, 4), $urandom_range(0, 7));
            end
            run_seq($urandom_range(1, 16), 1, 1'b0, -1, -1);
        end

        // Stop mid-RUN, then a fresh start runs again from entry 0
        wr(0, rnd_ctrl(), 2, $urandom_range(0, 7));
        wr(1, rnd_ctrl(), 3, $urandom_range(0, 7));
        wr(2, rnd_ctrl(), 1, $urandom_range(0, 7));
        run_seq(3, 1, 1'b0, 0, 1);
        run_seq(3, 1, 1'b0, -1, -1);

        // Table writes, starts and num changes while busy are ignored
        run_seq(3, 1, 1'b1, -1, -1);
        run_seq(3, 1, 1'b0, -1, -1);

        // Empty sequence
        run_seq(0, 1, 1'b0, -1, -1);

        // Reset mid-sequence returns to reset values, table survives
        start       = 1'b1;
        num_entries = 5'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_route", route_ctrl, 0);
        chk("midrst_flags", {busy, done, aborted}, 3'b000);
        chk("midrst_idx", cur_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_quiet", {busy, done, aborted}, 3'b000);
        m_route = '0;
        run_seq(3, 1, 1'b0, -1, -1);

`ifdef ROUTE_SCHED_LOOP_EN
        // Looping single entry reloads after each gap until stopped
        wr(0, rnd_ctrl() | 36'h1, 1, $urandom_range(0, 7));
        loop_en = 1'b1;
        run_seq(1, 3, 1'b0, 2, 0);
        loop_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
